// File: rtl/branch_predict_unit.sv
// Execute-stage conditional branch resolver with a PC-indexed table of saturating
// counters that gives fetch a taken/not-taken prediction, plus saturating statistics.
module branch_predict_unit #(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned BHT_ENTRIES = 64,
    parameter int unsigned CTR_BITS    = 2,
    parameter int unsigned STAT_W      = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [XLEN-1:0]   if_pc,
    output logic              if_pred_taken,
    input  logic              ex_valid,
    input  logic [XLEN-1:0]   ex_pc,
    input  logic [1:0]        ex_pcsrc_in,
    input  logic [2:0]        ex_funct3,
    input  logic              ex_br_eq,
    input  logic              ex_br_lt,
    input  logic              ex_br_ltu,
    input  logic              ex_pred_taken,
    output logic [1:0]        pcsrc,
    output logic              br_taken,
    output logic              mispredict,
    input  logic              stat_clr,
    output logic [STAT_W-1:0] stat_branches,
    output logic [STAT_W-1:0] stat_mispredicts
);

    localparam int unsigned IdxW = $clog2(BHT_ENTRIES);
    localparam logic [CTR_BITS-1:0] CtrMax  = {CTR_BITS{1'b1}};
    localparam logic [CTR_BITS-1:0] CtrInit = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);

    logic [CTR_BITS-1:0] bht_q [BHT_ENTRIES];
    logic [IdxW-1:0]     if_idx;
    logic [IdxW-1:0]     ex_idx;
    logic [CTR_BITS-1:0] ctr_cur;
    logic [CTR_BITS-1:0] ctr_d;
    logic                cond;
    logic                f3_legal;
    logic                is_br;
    logic [STAT_W-1:0]   stat_branches_q;
    logic [STAT_W-1:0]   stat_mispredicts_q;

    // PC bits outside the index field are intentionally ignored (no tags).
    logic unused_pc_bits;
    assign unused_pc_bits = ^{if_pc[XLEN-1:IdxW+2], if_pc[1:0],
                              ex_pc[XLEN-1:IdxW+2], ex_pc[1:0]};

    assign if_idx = if_pc[IdxW+1:2];
    assign ex_idx = ex_pc[IdxW+1:2];

    always_comb begin
        cond     = 1'b0;
        f3_legal = 1'b1;
        unique case (ex_funct3)
            3'b000:  cond = ex_br_eq;
            3'b001:  cond = ~ex_br_eq;
            3'b100:  cond = ex_br_lt;
            3'b101:  cond = ~ex_br_lt;
            3'b110:  cond = ex_br_ltu;
            3'b111:  cond = ~ex_br_ltu;
            default: f3_legal = 1'b0;
        endcase
    end

    assign is_br = ex_valid & (ex_pcsrc_in == 2'b01) & f3_legal;

    always_comb begin
        pcsrc    = ex_pcsrc_in;
        br_taken = 1'b0;
        if (ex_valid && ex_pcsrc_in == 2'b01) begin
            pcsrc    = (is_br && cond) ? 2'b01 : 2'b00;
            br_taken = is_br & cond;
        end
    end

    assign mispredict = is_br & (cond != ex_pred_taken);

    assign ctr_cur = bht_q[ex_idx];

    always_comb begin
        ctr_d = ctr_cur;
        if (cond) begin
            if (ctr_cur != CtrMax) ctr_d = ctr_cur + CTR_BITS'(1);
        end else begin
            if (ctr_cur != '0) ctr_d = ctr_cur - CTR_BITS'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(BHT_ENTRIES); i++) begin
                bht_q[i] <= CtrInit;
            end
        end else if (is_br) begin
            bht_q[ex_idx] <= ctr_d;
        end
    end

    // Read straight from the table: a same-cycle update is not bypassed.
    assign if_pred_taken = bht_q[if_idx][CTR_BITS-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_branches_q    <= '0;
            stat_mispredicts_q <= '0;
        end else if (stat_clr) begin
            stat_branches_q    <= '0;
            stat_mispredicts_q <= '0;
        end else begin
            if (is_br && stat_branches_q != '1) begin
                stat_branches_q <= stat_branches_q + STAT_W'(1);
            end
            if (mispredict && stat_mispredicts_q != '1) begin
                stat_mispredicts_q <= stat_mispredicts_q + STAT_W'(1);
            end
        end
    end

    assign stat_branches    = stat_branches_q;
    assign stat_mispredicts = stat_mispredicts_q;

endmodule

// File: tb/tb_branch_predict_unit.sv
// Randomised self-checking bench for branch_predict_unit against a behavioural model
// that resolves branches from the raw operand values.
module tb_branch_predict_unit;

    localparam int unsigned Entries = 64;
    localparam int unsigned StatMax = 15;

    logic        clk;
    logic        rst_n;
    logic [31:0] if_pc;
    logic        if_pred_taken;
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic [1:0]  ex_pcsrc_in;
    logic [2:0]  ex_funct3;
    logic        ex_br_eq;
    logic        ex_br_lt;
    logic        ex_br_ltu;
    logic        ex_pred_taken;
    logic [1:0]  pcsrc;
    logic        br_taken;
    logic        mispredict;
    logic        stat_clr;
    logic [3:0]  stat_branches;
    logic [3:0]  stat_mispredicts;

    int errors = 0;
    int checks = 0;

    int          m_ctr [Entries];
    int          m_br;
    int          m_mp;
    logic [31:0] cur_a;
    logic [31:0] cur_b;

    branch_predict_unit #(
        .XLEN       (32),
        .BHT_ENTRIES(Entries),
        .CTR_BITS   (2),
        .STAT_W     (4)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .if_pc           (if_pc),
        .if_pred_taken   (if_pred_taken),
        .ex_valid        (ex_valid),
        .ex_pc           (ex_pc),
        .ex_pcsrc_in     (ex_pcsrc_in),
        .ex_funct3       (ex_funct3),
        .ex_br_eq        (ex_br_eq),
        .ex_br_lt        (ex_br_lt),
        .ex_br_ltu       (ex_br_ltu),
        .ex_pred_taken   (ex_pred_taken),
        .pcsrc           (pcsrc),
        .br_taken        (br_taken),
        .mispredict      (mispredict),
        .stat_clr        (stat_clr),
        .stat_branches   (stat_branches),
        .stat_mispredicts(stat_mispredicts)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic int idx_of(input logic [31:0] pc);
        return int'((pc >> 2) % Entries);
    endfunction

    function automatic bit m_pred(input logic [31:0] pc);
        return m_ctr[idx_of(pc)] >= 2;
    endfunction

    function automatic bit m_is_br();
        return ex_valid && ex_pcsrc_in == 2'b01 && ex_funct3 != 3'b010 && ex_funct3 != 3'b011;
    endfunction

    function automatic bit m_cond();
        case (ex_funct3)
            3'b000:  return cur_a == cur_b;
            3'b001:  return cur_a != cur_b;
            3'b100:  return $signed(cur_a) < $signed(cur_b);
            3'b101:  return $signed(cur_a) >= $signed(cur_b);
            3'b110:  return cur_a < cur_b;
            3'b111:  return cur_a >= cur_b;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [1:0] m_pcsrc();
        if (!ex_valid || ex_pcsrc_in != 2'b01) return ex_pcsrc_in;
        if (m_is_br() && m_cond()) return 2'b01;
        return 2'b00;
    endfunction

    function automatic bit m_taken();
        return m_is_br() && m_cond();
    endfunction

    function automatic bit m_mis();
        return m_is_br() && (m_cond() != ex_pred_taken);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < int'(Entries); i++) m_ctr[i] = 1;
        m_br = 0;
        m_mp = 0;
    endtask

    // ---------------- stimulus helpers (no checking) ----------------
    task automatic drive(input bit v, input logic [31:0] pc, input logic [1:0] psel,
                         input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input bit pred);
        ex_valid      = v;
        ex_pc         = pc;
        ex_pcsrc_in   = psel;
        ex_funct3     = f3;
        cur_a         = a;
        cur_b         = b;
        ex_br_eq      = (a == b);
        ex_br_lt      = ($signed(a) < $signed(b));
        ex_br_ltu     = (a < b);
        ex_pred_taken = pred;
    endtask

    task automatic idle();
        drive(1'b0, 32'h0, 2'b00, 3'b000, 32'h0, 32'h1, 1'b0);
        stat_clr = 1'b0;
    endtask

    // Advance one clock edge, applying the model's view of the update; returns at negedge.
    task automatic commit();
        bit br;
        bit c;
        bit mp;
        int idx;
        br  = m_is_br();
        c   = m_cond();
        mp  = m_mis();
        idx = idx_of(ex_pc);
        @(posedge clk);
        if (stat_clr) begin
            m_br = 0;
            m_mp = 0;
        end else begin
            if (br && m_br < int'(StatMax)) m_br++;
            if (mp && m_mp < int'(StatMax)) m_mp++;
        end
        if (br) begin
            if (c) m_ctr[idx] = (m_ctr[idx] < 3) ? m_ctr[idx] + 1 : 3;
            else   m_ctr[idx] = (m_ctr[idx] > 0) ? m_ctr[idx] - 1 : 0;
        end
        @(negedge clk);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        idle();
        ex_valid    = 1'b0;
        ex_pcsrc_in = 2'b10;
        if_pc       = 32'h0;
        model_reset();
        @(negedge clk);
        #1;
        checks++;
        if (pcsrc !== 2'b10 || br_taken !== 1'b0 || mispredict !== 1'b0) begin
            errors++;
            $display("FAIL reset_comb: pcsrc=%b br_taken=%b mispredict=%b, want 10/0/0",
                     pcsrc, br_taken, mispredict);
        end
        @(negedge clk);
        rst_n = 1'b1;
        idle();
        for (int i = 0; i < int'(Entries); i++) begin
            if_pc = 32'(i * 4);
            #1;
            checks++;
            if (if_pred_taken !== 1'b0) begin
                errors++;
                $display("FAIL reset_pred: pc=%h got %b want 0", if_pc, if_pred_taken);
            end
        end
        checks++;
        if (stat_branches !== 4'd0 || stat_mispredicts !== 4'd0) begin
            errors++;
            $display("FAIL reset_stats: got %0d/%0d want 0/0", stat_branches, stat_mispredicts);
        end
        @(negedge clk);
    endtask

    task automatic test_beq();
        drive(1'b1, 32'h100, 2'b01, 3'b000, 32'd5, 32'd5, 1'b0);
        #1;
        checks++;
        if (pcsrc !== 2'b01 || br_taken !== 1'b1 || mispredict !== 1'b1) begin
            errors++;
            $display("FAIL beq_resolve: pcsrc=%b taken=%b mis=%b want 01/1/1",
                     pcsrc, br_taken, mispredict);
        end
        commit();
        idle();
        if_pc = 32'h100;
        #1;
        checks++;
        if (if_pred_taken !== 1'b1) begin
            errors++;
            $display("FAIL beq_pred: got %b want 1", if_pred_taken);
        end
        checks++;
        if (stat_branches !== 4'd1 || stat_mispredicts !== 4'd1) begin
            errors++;
            $display("FAIL beq_stats: got %0d/%0d want 1/1", stat_branches, stat_mispredicts);
        end
    endtask

    task automatic test_saturation();
        if_pc = 32'h40;
        for (int i = 0; i < 7; i++) begin
            // five taken BNE, then two not-taken
            if (i < 5) drive(1'b1, 32'h40, 2'b01, 3'b001, 32'd1, 32'd2, 1'b1);
            else       drive(1'b1, 32'h40, 2'b01, 3'b001, 32'd7, 32'd7, 1'b1);
            #1;
            checks++;
            if (mispredict !== m_mis() || pcsrc !== m_pcsrc()) begin
                errors++;
                $display("FAIL sat_resolve[%0d]: mis=%b pcsrc=%b want %b/%b",
                         i, mispredict, pcsrc, m_mis(), m_pcsrc());
            end
            commit();
            #1;
            checks++;
            if (if_pred_taken !== m_pred(32'h40)) begin
                errors++;
                $display("FAIL sat_pred[%0d]: got %b want %b", i, if_pred_taken, m_pred(32'h40));
            end
        end
        idle();
    endtask

    task automatic test_illegal_jump();
        drive(1'b1, 32'h100, 2'b01, 3'b010, 32'd3, 32'd3, 1'b1);
        #1;
        checks++;
        if (pcsrc !== 2'b00 || br_taken !== 1'b0 || mispredict !== 1'b0) begin
            errors++;
            $display("FAIL illegal_f3: pcsrc=%b taken=%b mis=%b want 00/0/0",
                     pcsrc, br_taken, mispredict);
        end
        commit();
        drive(1'b1, 32'h100, 2'b10, 3'b000, 32'd3, 32'd3, 1'b0);
        #1;
        checks++;
        if (pcsrc !== 2'b10 || br_taken !== 1'b0 || mispredict !== 1'b0) begin
            errors++;
            $display("FAIL jump: pcsrc=%b taken=%b mis=%b want 10/0/0",
                     pcsrc, br_taken, mispredict);
        end
        commit();
        idle();
        if_pc = 32'h100;
        #1;
        checks++;
        if (if_pred_taken !== m_pred(32'h100) || stat_branches !== 4'(m_br)
            || stat_mispredicts !== 4'(m_mp)) begin
            errors++;
            $display("FAIL illegal_jump_state: pred=%b stats=%0d/%0d want %b %0d/%0d",
                     if_pred_taken, stat_branches, stat_mispredicts,
                     m_pred(32'h100), m_br, m_mp);
        end
    endtask

    task automatic test_alias();
        for (int i = 0; i < 4; i++) begin
            logic [31:0] pc;
            bit          old;
            pc = (i % 2 == 0) ? 32'h0 : 32'h100;
            if (i == 0) drive(1'b1, pc, 2'b01, 3'b110, 32'd1, 32'd9, 1'b0);
            else        drive(1'b1, pc, 2'b01, 3'b110, 32'd9, 32'd1, 1'b1);
            if_pc = pc;
            old   = m_pred(pc);
            #1;
            checks++;
            if (if_pred_taken !== old) begin
                errors++;
                $display("FAIL alias_same_cycle[%0d]: got %b want %b", i, if_pred_taken, old);
            end
            commit();
            if_pc = (i % 2 == 0) ? 32'h100 : 32'h0;
            #1;
            checks++;
            if (if_pred_taken !== m_pred(if_pc)) begin
                errors++;
                $display("FAIL alias_other[%0d]: got %b want %b", i, if_pred_taken,
                         m_pred(if_pc));
            end
        end
        idle();
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            logic [31:0] a;
            logic [31:0] b;
            a = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 8)) : $urandom;
            b = ($urandom_range(0, 3) == 0) ? a : $urandom;
            if ($urandom_range(0, 1) == 0) b = 32'($urandom_range(0, 8));
            drive(1'($urandom_range(0, 7) != 0), {22'd0, 8'($urandom), 2'b00},
                  ($urandom_range(0, 2) != 0) ? 2'b01 : 2'($urandom),
                  3'($urandom), a, b, 1'($urandom));
            stat_clr = ($urandom_range(0, 19) == 0);
            if_pc    = {22'd0, 8'($urandom), 2'b00};
            #1;
            checks++;
            if (pcsrc !== m_pcsrc() || br_taken !== m_taken() || mispredict !== m_mis()
                || if_pred_taken !== m_pred(if_pc)) begin
                errors++;
                $display("FAIL rand_comb[%0d]: pcsrc=%b taken=%b mis=%b pred=%b want %b/%b/%b/%b",
                         i, pcsrc, br_taken, mispredict, if_pred_taken,
                         m_pcsrc(), m_taken(), m_mis(), m_pred(if_pc));
            end
            commit();
            checks++;
            if (stat_branches !== 4'(m_br) || stat_mispredicts !== 4'(m_mp)) begin
                errors++;
                $display("FAIL rand_stats[%0d]: got %0d/%0d want %0d/%0d",
                         i, stat_branches, stat_mispredicts, m_br, m_mp);
            end
        end
        idle();
    endtask

    task automatic test_stats_sat();
        stat_clr = 1'b1;
        commit();
        stat_clr = 1'b0;
        for (int i = 0; i < 20; i++) begin
            // BLT not taken (5 < 2 is false) while predicted taken
            drive(1'b1, 32'(i * 4), 2'b01, 3'b100, 32'd5, 32'd2, 1'b1);
            commit();
        end
        idle();
        checks++;
        if (stat_branches !== 4'd15 || stat_mispredicts !== 4'd15) begin
            errors++;
            $display("FAIL stats_saturate: got %0d/%0d want 15/15",
                     stat_branches, stat_mispredicts);
        end
    endtask

    task automatic test_stat_clr();
        drive(1'b1, 32'h8, 2'b01, 3'b000, 32'd1, 32'd2, 1'b1);
        stat_clr = 1'b1;
        commit();
        idle();
        checks++;
        if (stat_branches !== 4'd0 || stat_mispredicts !== 4'd0) begin
            errors++;
            $display("FAIL stat_clr_priority: got %0d/%0d want 0/0",
                     stat_branches, stat_mispredicts);
        end
        checks++;
        if_pc = 32'h8;
        #1;
        if (if_pred_taken !== m_pred(32'h8)) begin
            errors++;
            $display("FAIL stat_clr_table: got %b want %b", if_pred_taken, m_pred(32'h8));
        end
    endtask

    task automatic test_reset_mid();
        // push index 4 up to strongly taken first
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h10, 2'b01, 3'b000, 32'd4, 32'd4, 1'b1);
            commit();
        end
        if_pc = 32'h10;
        #1;
        checks++;
        if (if_pred_taken !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_pred: got %b want 1", if_pred_taken);
        end
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if (if_pred_taken !== 1'b0 || stat_branches !== 4'd0 || stat_mispredicts !== 4'd0) begin
            errors++;
            $display("FAIL async_reset: pred=%b stats=%0d/%0d want 0 0/0",
                     if_pred_taken, stat_branches, stat_mispredicts);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        idle();
        for (int i = 0; i < int'(Entries); i++) begin
            if_pc = 32'(i * 4);
            #1;
            checks++;
            if (if_pred_taken !== 1'b0) begin
                errors++;
                $display("FAIL reset_mid_pred: pc=%h got %b want 0", if_pc, if_pred_taken);
            end
        end
        // a single taken branch must now move index 4 from 01 to 10
        drive(1'b1, 32'h10, 2'b01, 3'b000, 32'd4, 32'd4, 1'b0);
        commit();
        idle();
        if_pc = 32'h10;
        #1;
        checks++;
        if (if_pred_taken !== 1'b1 || stat_branches !== 4'd1 || stat_mispredicts !== 4'd1) begin
            errors++;
            $display("FAIL post_reset_update: pred=%b stats=%0d/%0d want 1 1/1",
                     if_pred_taken, stat_branches, stat_mispredicts);
        end
    endtask

    initial begin
        stat_clr = 1'b0;
        test_reset();
        test_beq();
        test_saturation();
        test_illegal_jump();
        test_alias();
        test_random();
        test_stats_sat();
        test_stat_clr();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/branch_predict_unit.md
# branch_predict_unit

Parametrised successor to the execute-stage branch resolver. It resolves conditional branches from the comparator flags and funct3, and adds a PC-indexed branch history table (BHT) of saturating counters that supplies a taken/not-taken prediction to fetch. It flags mispredictions to the execute stage and keeps saturating branch and mispredict statistics. It sits between fetch (lookup port) and execute (resolve/update port) of the core.

## Interface
- XLEN, 32, PC width
- BHT_ENTRIES, 64, number of counters; power of 2, ≥2
- CTR_BITS, 2, counter width; ≥1
- STAT_W, 32, statistics counter width
- clk  in  1  rising-edge clock
- rst_n  in  1  reset; asynchronous, active-low
- if_pc  in  XLEN  fetch PC for lookup
- if_pred_taken  out  1  prediction for if_pc (MSB of indexed counter)
- ex_valid  in  1  execute-stage instruction valid
- ex_pc  in  XLEN  PC of the execute-stage instruction
- ex_pcsrc_in  in  2  decoder PC-select: 00 PC+4, 01 branch target, 10/11 jumps
- ex_funct3  in  3  branch condition
- ex_br_eq, ex_br_lt, ex_br_ltu  in  1 each  comparator flags
- ex_pred_taken  in  1  prediction piped down with the instruction
- pcsrc  out  2  resolved PC-select
- br_taken  out  1  resolved conditional branch taken
- mispredict  out  1  resolved direction ≠ ex_pred_taken
- stat_clr  in  1  synchronous clear of statistics
- stat_branches  out  STAT_W  resolved conditional branches
- stat_mispredicts  out  STAT_W  mispredicted branches

## Operation
- IDX_W = log2(BHT_ENTRIES). Index = pc[IDX_W+1:2] for both ports. No tags; aliasing is accepted.
- is_br = ex_valid & (ex_pcsrc_in == 01) & funct3 ∈ {000,001,100,101,110,111}.
- Condition by funct3:
  - 000: eq
  - 001: !eq
  - 100: lt
  - 101: !lt
  - 110: ltu
  - 111: !ltu
- Branch resolution, combinational:
  - is_br: pcsrc = cond ? 01 : 00; br_taken = cond.
  - ex_pcsrc_in == 01 with funct3 010/011 (illegal): pcsrc = 00, br_taken = 0, no update, no statistics.
  - ex_pcsrc_in ≠ 01: pcsrc = ex_pcsrc_in unchanged, br_taken = 0.
  - ex_valid = 0: pcsrc = ex_pcsrc_in, br_taken = 0, mispredict = 0.
- mispredict = is_br & (cond ≠ ex_pred_taken), combinational. Jumps never raise mispredict.
- Counter update on the clk edge when is_br:
  - taken: ctr = min(ctr+1, 2^CTR_BITS−1).
  - not-taken: ctr = max(ctr−1, 0).
- Prediction: if_pred_taken = ctr[if_idx][CTR_BITS−1], combinational from registered state.
- Statistics, on the clk edge:
  - stat_clr = 1: both counters go to 0. Clear has priority over increment in the same cycle.
  - Otherwise stat_branches += is_br and stat_mispredicts += mispredict.
  - Both saturate at all-ones; no wrap-around.

## Timing
- Reset (rst_n low, async): every BHT counter = 2^(CTR_BITS−1)−1 (weakly not-taken; 01 for CTR_BITS=2). Stats = 0. if_pred_taken = 0.
- Outputs with inputs stable during reset: pcsrc, br_taken and mispredict follow the combinational rules above.
- Reset asserted mid-operation: any pending same-cycle update is discarded. Table and stats reinitialise immediately.
- pcsrc, br_taken, mispredict: zero-cycle latency from execute inputs.
- Counter update is visible at if_pred_taken one cycle after the resolving edge.
- Same-index read/write in the same cycle: if_pred_taken shows the pre-update value. There is no bypass.
- One update per cycle maximum.

## Test plan
- Reset, then sweep if_pc = 0x0..0xFC step 4 → if_pred_taken = 0 for all 64 indices; both stats = 0.
- BEQ resolution:
  - ex_pc = 0x100, funct3 = 000, eq = 1, pred = 0 → pcsrc = 01, mispredict = 1.
  - Next cycle: counter 01→10, and if_pc = 0x100 gives if_pred_taken = 1.
  - Stats = 1/1.
- Saturation at index 0x40 with CTR_BITS = 2:
  - Four taken BNE (eq = 0) → counter = 11. A fifth taken keeps 11.
  - One not-taken → 10, still predicted taken.
- Illegal funct3 = 010 and jump pcsrc_in = 10, each with ex_valid = 1:
  - Illegal funct3 → pcsrc = 00.
  - Jump → pcsrc = 10.
  - Both: mispredict = 0, no counter change, stats unchanged.
- Aliasing: branches at 0x0 and 0x100 (BHT_ENTRIES = 64) update the same counter. Same-cycle if_pc = ex_pc returns the old prediction.
- Stats:
  - With STAT_W = 4, 20 mispredicted branches → both stats = 15.
  - stat_clr asserted with a resolving branch in the same cycle → both stats = 0.
  - rst_n pulsed mid-stream → table back to 01.
